// File: rtl/hwrandom_pool.sv
// Purpose : XOR/sync raw oscillator bits, Von Neumann de-bias them, pack them into words, buffer the words, and dispatch them round-robin.
// Latency : raw input to de-biased bit is 2-3 cycles; last bit of a word to the earliest out_start is 2 cycles.
// Backpressure: dispatch waits on the current port while its out_ready is low; a push into a full FIFO is dropped.
// Ports   : clk, reset (async, active-low); raw_bits[NUM_SOURCES]; health_clear (pulse);
//           out_word/out_start[NUM_PORTS]/out_ready[NUM_PORTS] (start/ready transmitters); fifo_level; health_fail (sticky).
// Option  : define HWRANDOM_POOL_DROP_COUNT_EN to add drop_count[15:0], a saturating count of words dropped on a full FIFO.

module hwrandom_pool_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_vld_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_pop;
    logic             do_push;

    // A full FIFO still accepts a push when a pop happens in the same cycle.
    always_comb begin
        do_pop  = pop_i && (level_q != '0);
        do_push = push_vld_i && ((level_q != (AW+1)'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;
endmodule

module hwrandom_pool #(
    parameter int NUM_SOURCES = 241,
    parameter int WORD_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int NUM_PORTS   = 1,
    parameter int REP_LIMIT   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SOURCES-1:0]      raw_bits,
    input  logic                        health_clear,
    output logic [WORD_WIDTH-1:0]       out_word,
    output logic [NUM_PORTS-1:0]        out_start,
    input  logic [NUM_PORTS-1:0]        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        health_fail
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
    ,
    output logic [15:0]                 drop_count
`endif
);
    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Sampling and de-bias
    logic                  sync1_q, sync2_q;
    logic                  phase_q;
    logic                  a_q;
    logic                  bit_vld;
    logic                  bit_dat;

    // Health test
    logic                  last_bit_q;
    logic [RW-1:0]         run_q;
    logic [RW-1:0]         run_inc;
    logic                  trip;
    logic                  fail_q;

    // Word assembly
    logic [WORD_WIDTH-1:0] word_q;
    logic [CW-1:0]         cnt_q;
    logic                  push_q;
    logic                  push_vld;

    // Buffer and dispatch
    logic [WORD_WIDTH-1:0] fifo_head;
    logic [LW-1:0]         fifo_lvl;
    logic                  fire;
    logic [PW-1:0]         ptr_q;
    logic [NUM_PORTS-1:0]  out_start_q;
    logic [WORD_WIDTH-1:0] out_word_q;

    // The oscillators are unrelated to clk, so only the XOR is synchronised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            phase_q <= 1'b0;
            a_q     <= 1'b0;
        end else begin
            sync1_q <= ^raw_bits;
            sync2_q <= sync1_q;
            phase_q <= ~phase_q;
            if (!phase_q) a_q <= sync2_q;
        end
    end

    // Phase 1 holds the second sample of the pair; an unequal pair yields its first sample.
    always_comb begin
        bit_vld = phase_q && (a_q != sync2_q);
        bit_dat = a_q;
    end

    // A run count of 0 means "no previous bit", so the next bit always starts a run of 1.
    always_comb begin
        run_inc = RW'(1);
        if ((run_q != '0) && (bit_dat == last_bit_q)) begin
            run_inc = (run_q == RW'(REP_LIMIT)) ? run_q : run_q + RW'(1);
        end
        trip = bit_vld && (run_inc == RW'(REP_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_q     <= 1'b0;
            run_q      <= '0;
            last_bit_q <= 1'b0;
        end else if (trip) begin
            // A trip wins over a simultaneous health_clear.
            fail_q     <= 1'b1;
            run_q      <= run_inc;
            last_bit_q <= bit_dat;
        end else if (health_clear) begin
            fail_q <= 1'b0;
            run_q  <= '0;
        end else if (bit_vld) begin
            run_q      <= run_inc;
            last_bit_q <= bit_dat;
        end
    end

    // Bits are packed LSB first; the completed word is pushed one cycle later.
    // Nothing is assembled while the health test is failed, so a cleared pool starts on a fresh word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (trip || health_clear) begin
                cnt_q <= '0;
            end else if (bit_vld && !fail_q) begin
                word_q[cnt_q] <= bit_dat;
                if (cnt_q == CW'(WORD_WIDTH - 1)) begin
                    cnt_q  <= '0;
                    push_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign push_vld = push_q && !fail_q;

    hwrandom_pool_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (trip),
        .push_vld_i (push_vld),
        .push_dat_i (word_q),
        .pop_i      (fire),
        .head_dat_o (fifo_head),
        .level_o    (fifo_lvl)
    );

    // A start in the previous cycle blocks dispatch, so starts never land back to back.
    // The pointer only moves on a send, so a busy port is waited on rather than skipped.
    always_comb begin
        fire = (fifo_lvl != '0) && out_ready[ptr_q] && !fail_q && (out_start_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            out_start_q <= '0;
            out_word_q  <= '0;
        end else begin
            out_start_q <= '0;
            if (fire) begin
                out_start_q <= NUM_PORTS'(1) << ptr_q;
                out_word_q  <= fifo_head;
                ptr_q       <= (ptr_q == PW'(NUM_PORTS - 1)) ? '0 : ptr_q + PW'(1);
            end
        end
    end

`ifdef HWRANDOM_POOL_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic        drop;

    // Full and no pop this cycle is exactly when the FIFO refuses the push.
    always_comb begin
        drop = push_vld && (fifo_lvl == LW'(FIFO_DEPTH)) && !fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (health_clear) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

    assign out_word    = out_word_q;
    assign out_start   = out_start_q;
    assign fifo_level  = fifo_lvl;
    assign health_fail = fail_q;
endmodule

// File: tb/tb_hwrandom_pool.sv
module tb_hwrandom_pool;
    localparam int NS = 241;
    localparam int WW = 8;
    localparam int FD = 16;
    localparam int NP = 3;
    localparam int RL = 32;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NS-1:0] raw_bits = '0;
    logic          health_clear = 1'b0;
    logic [WW-1:0] out_word;
    logic [NP-1:0] out_start;
    logic [NP-1:0] out_ready = '0;
    logic [LW-1:0] fifo_level;
    logic          health_fail;
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    hwrandom_pool #(
        .NUM_SOURCES (NS),
        .WORD_WIDTH  (WW),
        .FIFO_DEPTH  (FD),
        .NUM_PORTS   (NP),
        .REP_LIMIT   (RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_bits     (raw_bits),
        .health_clear (health_clear),
        .out_word     (out_word),
        .out_start    (out_start),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .health_fail  (health_fail)
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus stream: one raw bit per cycle, grouped in pairs
    bit  stim_q[$];
    bit  rand_raw = 1'b0;
    int  edge_n = 0;
    int  drv_phase = 0;
    bit  in_pair = 1'b0;

    typedef struct { bit b; bit is_b; int ce; } pent_t;
    pent_t pipe[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic drive_raw(input bit v);
        logic [NS-1:0] r;
        int idx;
        if (!rand_raw) begin
            r = '0;
            r[0] = v;
        end else begin
            for (int i = 0; i < NS; i++) r[i] = 1'($urandom_range(0, 1));
            if ((^r) != v) begin
                idx = $urandom_range(0, NS - 1);
                r[idx] = ~r[idx];
            end
        end
        raw_bits = r;
    endtask

    always @(negedge clk) begin
        bit     b;
        pent_t  e;
        if (!reset) begin
            drv_phase = 0;
            in_pair = 1'b0;
            raw_bits = '0;
        end else begin
            b = 1'b0;
            if (drv_phase == 0) begin
                if (stim_q.size() >= 2) begin
                    b = stim_q.pop_front();
                    in_pair = 1'b1;
                end
            end else begin
                if (in_pair) b = stim_q.pop_front();
                in_pair = 1'b0;
            end
            drive_raw(b);
            // Sampled at edge_n+1, visible to the de-biaser two edges later.
            e.b = b;
            e.is_b = (drv_phase == 1);
            e.ce = edge_n + 3;
            pipe.push_back(e);
            drv_phase = 1 - drv_phase;
        end
    end

    task automatic send_bit(input bit v);
        stim_q.push_back(v);
        stim_q.push_back(~v);
    endtask

    task automatic send_idle_maybe();
        bit v;
        if ($urandom_range(0, 2) == 0) begin
            v = 1'($urandom_range(0, 1));
            stim_q.push_back(v);
            stim_q.push_back(v);
        end
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit idle);
        for (int k = 0; k < WW; k++) begin
            if (idle) send_idle_maybe();
            send_bit(w[k]);
        end
    endtask

    // ---------------- reference model: pairs -> bits -> words -> queue of expected words
    logic [WW-1:0] exp_q[$];
    bit            m_a, m_last, m_fail, m_push_pend;
    int            m_run, m_cnt, m_push_edge, m_drops;
    int            m_clr_edge = -1;
    logic [WW-1:0] m_word, m_push_word;

    always @(negedge clk) begin
        pent_t e;
        bit    bv;
        #1;
        if (!reset) begin
            exp_q.delete();
            pipe.delete();
            m_a = 0; m_last = 0; m_fail = 0; m_push_pend = 0;
            m_run = 0; m_cnt = 0; m_drops = 0; m_word = '0;
            m_clr_edge = -1;
        end else begin
            if (m_push_pend && (m_push_edge == edge_n)) begin
                m_push_pend = 0;
                if (exp_q.size() < FD) exp_q.push_back(m_push_word);
                else if (m_drops < 16'hFFFF) m_drops++;
            end
            if (m_clr_edge == edge_n) begin
                m_fail = 0; m_run = 0; m_cnt = 0; m_drops = 0;
            end
            while (pipe.size() > 0 && pipe[0].ce <= edge_n) begin
                e = pipe.pop_front();
                if (!e.is_b) begin
                    m_a = e.b;
                end else if (m_a != e.b) begin
                    bv = m_a;
                    if (m_run == 0 || bv != m_last) m_run = 1;
                    else if (m_run < RL) m_run++;
                    m_last = bv;
                    if (m_run == RL) begin
                        m_fail = 1;
                        exp_q.delete();
                        m_cnt = 0;
                    end else if (!m_fail) begin
                        m_word[m_cnt] = bv;
                        m_cnt++;
                        if (m_cnt == WW) begin
                            m_cnt = 0;
                            m_push_pend = 1;
                            m_push_edge = edge_n + 1;
                            m_push_word = m_word;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor: pops the scoreboard on every start
    logic [NP-1:0] rdy_at_edge = '0;
    logic [NP-1:0] prev_start = '0;
    int            m_ptr = 0;
    int            starts_seen = 0;

    always @(posedge clk) rdy_at_edge = out_ready;

    always @(negedge clk) begin
        bit exp_fire;
        if (!reset) begin
            prev_start = '0;
            m_ptr = 0;
        end else begin
            exp_fire = (exp_q.size() > 0) && rdy_at_edge[m_ptr] && !m_fail && (prev_start == '0);
            check("dispatch_fire", longint'(out_start != '0), longint'(exp_fire));
            if (out_start != '0) begin
                check("start_port", out_start, NP'(1) << m_ptr);
                if (exp_q.size() == 0) begin
                    check("start_with_empty_model", 1, 0);
                end else begin
                    check("out_word", out_word, exp_q.pop_front());
                end
                m_ptr = (m_ptr + 1) % NP;
                starts_seen++;
            end
            prev_start = out_start;
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            check("fifo_level", fifo_level, exp_q.size());
            check("health_fail", health_fail, m_fail);
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
            check("drop_count", drop_count, m_drops);
`endif
        end
    end

    // ---------------- helpers
    task automatic settle();
        int n = 0;
        while (stim_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("stim_timeout", longint'(n >= 5000), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        settle();
        while ((m_push_pend || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", longint'(n >= budget), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_word", out_word, 0);
        check("rst_out_start", out_start, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_health_fail", health_fail, 0);
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
        check("rst_drop_count", drop_count, 0);
`endif
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios
    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();
        release_reset();

        // Fixed pattern on bit 0 only: 10,00,01,10,10,11,01,01,10,01 -> 0x4D
        out_ready = '1;
        begin
            bit pat[20] = '{1,0, 0,0, 0,1, 1,0, 1,0, 1,1, 0,1, 0,1, 1,0, 0,1};
            for (int i = 0; i < 20; i++) stim_q.push_back(pat[i]);
        end
        drain(200);
        check("t1_starts", starts_seen, 1);
        check("t1_word", out_word, 8'h4D);
        check("t1_level", fifo_level, 0);

        // 17 random words with no ready: 16 buffered, 1 dropped, then drained in order
        rand_raw = 1'b1;
        out_ready = '0;
        s0 = starts_seen;
        for (int i = 0; i < 17; i++) send_word(WW'($urandom), 1'b1);
        settle();
        check("t2_level_full", fifo_level, FD);
        check("t2_no_starts", starts_seen - s0, 0);
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
        check("t2_drop_one", drop_count, 1);
`endif
        out_ready = '1;
        drain(200);
        check("t2_starts", starts_seen - s0, 16);

        // Round robin with 4 buffered words
        out_ready = '0;
        s0 = starts_seen;
        for (int i = 0; i < 4; i++) send_word(WW'($urandom), 1'b1);
        settle();
        out_ready = '1;
        drain(100);
        check("t3_starts", starts_seen - s0, 4);

        // Port 1 not ready: pointer must stall on it
        out_ready = '0;
        for (int i = 0; i < 3; i++) send_word(WW'($urandom), 1'b1);
        settle();
        out_ready = 3'b101;
        n = 0;
        while (m_ptr != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_reach_port1", m_ptr, 1);
        s0 = starts_seen;
        repeat (20) @(negedge clk);
        check("t3_stall", starts_seen - s0, 0);
        out_ready = '1;
        drain(100);

        // Repetition trip: one 0 then 32 ones, with words buffered
        out_ready = '0;
        for (int i = 0; i < 2; i++) send_word(WW'($urandom), 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < RL; i++) send_bit(1'b1);
        settle();
        check("t4_fail", health_fail, 1);
        check("t4_flushed", fifo_level, 0);
        s0 = starts_seen;
        out_ready = '1;
        repeat (10) @(negedge clk);
        check("t4_no_starts", starts_seen - s0, 0);
        @(negedge clk);
        health_clear = 1'b1;
        m_clr_edge = edge_n + 1;
        @(negedge clk);
        health_clear = 1'b0;
        send_word(8'h4D, 1'b0);
        drain(200);
        check("t4_recovered", health_fail, 0);
        check("t4_one_word", starts_seen - s0, 1);
        check("t4_word", out_word, 8'h4D);

        // Reset in the middle of a word with a word buffered
        out_ready = '0;
        send_word(WW'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        settle();
        #3 reset = 1'b0;
        stim_q.delete();
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();
        release_reset();
        s0 = starts_seen;
        out_ready = '1;
        send_word(WW'($urandom), 1'b1);
        drain(200);
        check("t5_one_word", starts_seen - s0, 1);

        // Full FIFO with push and pop landing on the same edge
        out_ready = '0;
        for (int i = 0; i < FD; i++) send_word(WW'($urandom), 1'b1);
        settle();
        check("t6_full", fifo_level, FD);
        s0 = starts_seen;
        send_word(WW'($urandom), 1'b1);
        n = 0;
        while (!m_push_pend && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t6_push_seen", longint'(n >= 500), 0);
        out_ready = '1;
        @(posedge clk);
        #1 out_ready = '0;
        repeat (3) @(negedge clk);
        #3;
        check("t6_level_kept", fifo_level, FD);
        check("t6_one_start", starts_seen - s0, 1);
`ifdef HWRANDOM_POOL_DROP_COUNT_EN
        check("t6_no_drop", drop_count, 0);
`endif
        out_ready = '1;
        drain(200);
        check("t6_all_out", starts_seen - s0, FD + 1);

        check("final_model_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
